// File: rtl/riscv_pipe_pkg.sv
// ---------------------------------------------------------------------------
// riscv_pipe_pkg
//   Shared definitions for the RISC-V pipeline stage register:
//     XLEN_DEFAULT      default PC field width
//     ILEN_DEFAULT      default instruction field width
//     NOP_INST_DEFAULT  canonical NOP (addi x0,x0,0) shown when a stage is empty
//     pipe_state_e      occupancy state; the encoding equals the number of
//                       held entries so it can be exported directly as occ
// ---------------------------------------------------------------------------
package riscv_pipe_pkg;

    localparam int          XLEN_DEFAULT     = 32;
    localparam int          ILEN_DEFAULT     = 32;
    localparam logic [31:0] NOP_INST_DEFAULT = 32'h0000_0013;

    // EMPTY: nothing held, FULL: output register loaded,
    // SKID: output register and skid slot both loaded (skid build only).
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } pipe_state_e;

    // Number of entries held in a given state.
    function automatic logic [1:0] state_occ(pipe_state_e s);
        return s;
    endfunction

endpackage

// File: rtl/pipe_skid_slot.sv
// ---------------------------------------------------------------------------
// pipe_skid_slot
//   Single data register used as the second (skid) entry of pipe_stage_reg.
//   Ports:
//     clk     rising-edge clock
//     reset   synchronous active-high reset, clears the slot
//     load    capture d at the next edge
//     clear   zero the slot at the next edge (wins over load)
//     d       incoming {inst, pc}
//     q       held {inst, pc}
// ---------------------------------------------------------------------------
module pipe_skid_slot #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         clear,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] data_q;
    logic [W-1:0] data_d;

    always_comb begin
        data_d = data_q;
        if (clear) begin
            data_d = '0;
        end else if (load) begin
            data_d = d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign q = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg
//   Valid/ready pipeline register carrying {instruction, PC} between two
//   RISC-V pipeline stages, with flush and one cycle of latency.
//
//   Build option (macro PIPE_SKID_EN):
//     undefined  one entry; in_ready = ~out_valid | out_ready (combinational)
//     defined    two entries (output register + pipe_skid_slot); in_ready is
//                a register equal to (state != SKID), so the upstream ready
//                path does not depend on out_ready
//
//   Ports:
//     clk        rising-edge clock
//     reset      synchronous active-high reset
//     in_valid   upstream entry present
//     in_ready   stage accepts the upstream entry this cycle
//     in_inst    upstream instruction (ILEN)
//     in_pc      upstream PC (XLEN)
//     flush      discard all held and incoming entries
//     out_valid  downstream entry present (registered)
//     out_ready  downstream consumes the entry this cycle
//     out_inst   held instruction, NOP_INST when empty (registered)
//     out_pc     held PC, 0 when empty (registered)
//     occ        number of held entries (0..2)
// ---------------------------------------------------------------------------
module pipe_stage_reg
    import riscv_pipe_pkg::*;
#(
    parameter int              XLEN     = XLEN_DEFAULT,
    parameter int              ILEN     = ILEN_DEFAULT,
    parameter logic [ILEN-1:0] NOP_INST = ILEN'(NOP_INST_DEFAULT)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [ILEN-1:0] in_inst,
    input  logic [XLEN-1:0] in_pc,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [ILEN-1:0] out_inst,
    output logic [XLEN-1:0] out_pc,
    output logic [1:0]      occ
);

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    pipe_state_e     state_q,     state_d;
    logic            out_valid_q, out_valid_d;
    logic [ILEN-1:0] out_inst_q,  out_inst_d;
    logic [XLEN-1:0] out_pc_q,    out_pc_d;

    logic accept;
    logic consume;

    // A flushed cycle neither accepts nor consumes; the flush branch below
    // clears everything regardless, but masking here keeps the intent local.
    assign accept  = in_valid & in_ready & ~flush;
    assign consume = out_valid_q & out_ready & ~flush;

`ifdef PIPE_SKID_EN
    // ------------------------------------------------------------------
    // Skid entry: catches the accept that arrives while the output
    // register is stalled.
    // ------------------------------------------------------------------
    logic                 in_ready_q, in_ready_d;
    logic                 skid_load;
    logic                 skid_clear;
    logic [ILEN+XLEN-1:0] skid_data;

    pipe_skid_slot #(
        .W (ILEN + XLEN)
    ) u_skid (
        .clk   (clk),
        .reset (reset),
        .load  (skid_load),
        .clear (skid_clear),
        .d     ({in_inst, in_pc}),
        .q     (skid_data)
    );

    assign in_ready = in_ready_q;
`else
    // Single entry: a slot frees up in the same cycle it is consumed.
    assign in_ready = ~out_valid_q | out_ready;
`endif

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        out_inst_d  = out_inst_q;
        out_pc_d    = out_pc_q;
`ifdef PIPE_SKID_EN
        skid_load   = 1'b0;
        skid_clear  = 1'b0;
`endif

        if (flush) begin
            state_d     = EMPTY;
            out_valid_d = 1'b0;
            out_inst_d  = NOP_INST;
            out_pc_d    = '0;
`ifdef PIPE_SKID_EN
            skid_clear  = 1'b1;
`endif
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_d     = FULL;
                        out_valid_d = 1'b1;
                        out_inst_d  = in_inst;
                        out_pc_d    = in_pc;
                    end
                end

                FULL: begin
                    if (accept && consume) begin
                        // Pass-through: new entry replaces the consumed one.
                        out_inst_d = in_inst;
                        out_pc_d   = in_pc;
                    end else if (consume) begin
                        state_d     = EMPTY;
                        out_valid_d = 1'b0;
                        out_inst_d  = NOP_INST;
                        out_pc_d    = '0;
`ifdef PIPE_SKID_EN
                    end else if (accept) begin
                        // Output stalled: park the new entry behind it.
                        state_d   = SKID;
                        skid_load = 1'b1;
`endif
                    end
                end

`ifdef PIPE_SKID_EN
                SKID: begin
                    // in_ready is low here, so only a consume can happen.
                    if (consume) begin
                        state_d    = FULL;
                        out_inst_d = skid_data[ILEN+XLEN-1:XLEN];
                        out_pc_d   = skid_data[XLEN-1:0];
                        skid_clear = 1'b1;
                    end
                end
`endif

                default: begin
                    state_d     = EMPTY;
                    out_valid_d = 1'b0;
                    out_inst_d  = NOP_INST;
                    out_pc_d    = '0;
                end
            endcase
        end

`ifdef PIPE_SKID_EN
        // Registered ready: reflects the state being entered, so it is
        // already correct in the cycle after each transition.
        in_ready_d = (state_d != SKID);
`endif
    end

    // ------------------------------------------------------------------
    // Registers; reset beats flush, accept and consume.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= EMPTY;
            out_valid_q <= 1'b0;
            out_inst_q  <= NOP_INST;
            out_pc_q    <= '0;
`ifdef PIPE_SKID_EN
            in_ready_q  <= 1'b1;
`endif
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_inst_q  <= out_inst_d;
            out_pc_q    <= out_pc_d;
`ifdef PIPE_SKID_EN
            in_ready_q  <= in_ready_d;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign out_inst  = out_inst_q;
    assign out_pc    = out_pc_q;
    assign occ       = state_occ(state_q);

endmodule

// File: tb/tb_pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// tb_pipe_stage_reg
//   Directed bench for pipe_stage_reg. A queue model holds the entries the
//   stage should contain; outputs are compared against it every cycle, and
//   literal expectations pin the key scenarios. Works with or without
//   PIPE_SKID_EN defined.
// ---------------------------------------------------------------------------
module tb_pipe_stage_reg;

    localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef PIPE_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_inst;
    logic [31:0] in_pc;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic [1:0]  occ;

    always #5 clk = ~clk;

    pipe_stage_reg dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_inst   (in_inst),
        .in_pc     (in_pc),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_inst  (out_inst),
        .out_pc    (out_pc),
        .occ       (occ)
    );

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } entry_t;

    entry_t mq[$];
    int     total = 0;
    int     bad   = 0;
    bit     model_on = 1'b0;
    bit     m_acc, m_con;
    entry_t m_e;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Stage can take a new entry: room left, or (single entry) the held one leaves now.
    function automatic bit model_ready();
        if (CAP == 2) return mq.size() < 2;
        else          return (mq.size() == 0) || out_ready;
    endfunction

    // Model update at each rising edge.
    always @(posedge clk) begin
        if (reset) begin
            mq.delete();
            model_on = 1'b1;
        end else if (model_on) begin
            if (flush) begin
                mq.delete();
            end else begin
                m_acc = in_valid && model_ready();
                m_con = (mq.size() > 0) && out_ready;
                if (m_con) void'(mq.pop_front());
                if (m_acc) begin
                    m_e.inst = in_inst;
                    m_e.pc   = in_pc;
                    mq.push_back(m_e);
                end
            end
        end
    end

    // Per-cycle comparison on the falling edge.
    always @(negedge clk) begin
        if (model_on) begin
            chk("out_valid", 64'(out_valid), 64'(mq.size() > 0));
            chk("out_inst",  64'(out_inst),  64'((mq.size() > 0) ? mq[0].inst : NOP));
            chk("out_pc",    64'(out_pc),    64'((mq.size() > 0) ? mq[0].pc : 32'h0));
            chk("occ",       64'(occ),       64'(mq.size()));
            chk("in_ready",  64'(in_ready),  64'(model_ready()));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] inst, input logic [31:0] pc);
        in_valid = 1'b1;
        in_inst  = inst;
        in_pc    = pc;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_inst = '0; in_pc = '0; out_ready = 1'b0;
        step(); step();
        reset = 1'b0;
        step();

        // Idle after reset
        chk("rst_valid",  64'(out_valid), 64'(0));
        chk("rst_inst",   64'(out_inst),  64'(32'h13));
        chk("rst_pc",     64'(out_pc),    64'(0));
        chk("rst_occ",    64'(occ),       64'(0));
        chk("rst_ready",  64'(in_ready),  64'(1));

        // Streaming with out_ready=1
        out_ready = 1'b1;
        offer(32'h0050_0093, 32'h0);
        step();
        chk("s1_inst", 64'(out_inst), 64'(32'h0050_0093));
        chk("s1_pc",   64'(out_pc),   64'(0));
        chk("s1_occ",  64'(occ),      64'(1));
        offer(32'h00A0_0113, 32'h4);
        step();
        chk("s2_inst", 64'(out_inst), 64'(32'h00A0_0113));
        chk("s2_pc",   64'(out_pc),   64'(4));
        chk("s2_occ",  64'(occ),      64'(1));
        in_valid = 1'b0;
        step();
        chk("s3_occ",  64'(occ),      64'(0));

`ifdef PIPE_SKID_EN
        // Back-pressure into the skid slot
        out_ready = 1'b0;
        offer(32'hA0, 32'h0); step();
        chk("bp_occ1",   64'(occ),      64'(1));
        offer(32'hA4, 32'h4); step();
        chk("bp_occ2",   64'(occ),      64'(2));
        chk("bp_ready0", 64'(in_ready), 64'(0));
        chk("bp_pc0",    64'(out_pc),   64'(0));
        offer(32'hA8, 32'h8); step();
        chk("bp_hold",   64'(out_pc),   64'(0));
        out_ready = 1'b1; step();
        chk("bp_rel4",   64'(out_pc),   64'(4));
        step();
        chk("bp_rel8",   64'(out_pc),   64'(8));
        in_valid = 1'b0; step();
        chk("bp_drain",  64'(occ),      64'(0));

        // Flush while in SKID with an incoming entry
        out_ready = 1'b0;
        offer(32'hB0, 32'h0); step();
        offer(32'hB4, 32'h4); step();
        chk("fl_pre_occ", 64'(occ), 64'(2));
`else
        // Single entry: ready mirrors out_ready while holding
        out_ready = 1'b0;
        offer(32'hA0, 32'h0); step();
        chk("bp_occ1",   64'(occ),      64'(1));
        chk("bp_ready0", 64'(in_ready), 64'(0));
        offer(32'hA4, 32'h4); step();
        chk("bp_hold",   64'(out_pc),   64'(0));
        out_ready = 1'b1; #1;
        chk("tg_rdy1",   64'(in_ready), 64'(1));
        step();
        chk("tg_pc4",    64'(out_pc),   64'(4));
        offer(32'hA8, 32'h8);
        out_ready = 1'b0; #1;
        chk("tg_rdy0",   64'(in_ready), 64'(0));
        step();
        chk("tg_hold4",  64'(out_pc),   64'(4));
        out_ready = 1'b1; #1;
        chk("tg_rdy1b",  64'(in_ready), 64'(1));
        step();
        chk("tg_pc8",    64'(out_pc),   64'(8));
        in_valid = 1'b0; step();
        chk("tg_drain",  64'(occ),      64'(0));

        // Flush while FULL with an incoming entry
        out_ready = 1'b0;
        offer(32'hB0, 32'h0); step();
        chk("fl_pre_occ", 64'(occ), 64'(1));
`endif
        flush = 1'b1;
        offer(32'hBC, 32'hC);
        step();
        flush = 1'b0; in_valid = 1'b0;
        chk("fl_occ",   64'(occ),       64'(0));
        chk("fl_valid", 64'(out_valid), 64'(0));
        chk("fl_inst",  64'(out_inst),  64'(32'h13));
        out_ready = 1'b1;
        step(); step();
        chk("fl_gone",  64'(out_valid), 64'(0));

        // Reset and flush together while FULL and accepting
        offer(32'hC0, 32'h10); step();
        chk("rf_pre", 64'(occ), 64'(1));
        reset = 1'b1; flush = 1'b1;
        offer(32'hC4, 32'h14);
        step();
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0;
        chk("rf_valid", 64'(out_valid), 64'(0));
        chk("rf_inst",  64'(out_inst),  64'(32'h13));
        chk("rf_pc",    64'(out_pc),    64'(0));
        chk("rf_occ",   64'(occ),       64'(0));
        chk("rf_ready", 64'(in_ready),  64'(1));
        step();
        chk("rf_nobeat", 64'(out_valid), 64'(0));

        // Mixed pattern, checked by the per-cycle model compare
        for (int i = 0; i < 60; i++) begin
            in_valid  = (i % 3) != 2;
            out_ready = (i % 4) != 1 && (i % 7) != 3;
            flush     = (i == 37);
            in_inst   = 32'h1000 + 32'(i);
            in_pc     = 32'(i) * 4;
            step();
        end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) step();
        chk("end_occ", 64'(occ), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
